// File: rtl/hc194_pkg.sv
// rtl/hc194_pkg.sv - shared op/state enums and count-width helper for the HC194 sequencer
package hc194_pkg;

    // Op codes double as the HC194 S mode-select code
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_RESP
    } state_e;

    // Width of a counter able to hold 0..data_w inclusive
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/hc194_seq_if.sv
// rtl/hc194_seq_if.sv - command/response handshake bundle between host and sequencer
interface hc194_seq_if #(
    parameter int DATA_W = 16
);
    import hc194_pkg::*;

    localparam int CNT_W = cnt_width(DATA_W);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0]        rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/hc194_model.sv
// rtl/hc194_model.sv - shadow copy of the HC194 register driven from the same mode pins
module hc194_model
    import hc194_pkg::*;
(
    input  logic       Clk,
    input  logic       MR,
    input  logic [1:0] s,
    input  logic       dsr,
    input  logic       dsl,
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Apply the HC194 mode rules on the same edge the real part does
    always_ff @(posedge Clk) begin
        if (MR) begin
            q <= 4'h0;
        end else begin
            case (op_e'(s))
                OP_HOLD: q <= q;
                OP_SHR:  q <= {q[2:0], dsr};
                OP_SHL:  q <= {dsl, q[3:1]};
                OP_LOAD: q <= d;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/hc194_seq.sv
// rtl/hc194_seq.sv - HC194 command sequencer; optional shadow checker under HC194_SEQ_CHECK_EN
module hc194_seq
    import hc194_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic        Clk,
    input  logic        MR,
    hc194_seq_if.slave  bus,
    output logic        err,
    output logic        hc_mr_n,
    output logic [1:0]  hc_s,
    output logic        hc_dsr,
    output logic        hc_dsl,
    output logic [3:0]  hc_d,
    input  logic [3:0]  hc_q
);

    localparam int               CNT_W   = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state;
    op_e               op_q;
    logic [CNT_W-1:0]  rem;
    logic [DATA_W-1:0] sr;
    op_e               cmd_op;
    logic [CNT_W-1:0]  cnt_eff;
    logic              mismatch;

    assign cmd_op  = op_e'(bus.cmd_op);
    assign cnt_eff = (bus.cmd_cnt > CNT_MAX) ? CNT_MAX : bus.cmd_cnt;

`ifdef HC194_SEQ_CHECK_EN
    logic [3:0] shadow_q;

    hc194_model u_model (
        .Clk (Clk),
        .MR  (MR),
        .s   (hc_s),
        .dsr (hc_dsr),
        .dsl (hc_dsl),
        .d   (hc_d),
        .q   (shadow_q)
    );

    assign mismatch = (hc_q != shadow_q);

    // Flag a readback that disagrees with the shadow; err is sticky until MR
    always_ff @(posedge Clk) begin
        if (MR) begin
            bus.rsp_err <= 1'b0;
            err         <= 1'b0;
        end else if (state == ST_SETTLE) begin
            bus.rsp_err <= mismatch;
            err         <= err | mismatch;
        end
    end
`else
    assign mismatch    = 1'b0;
    assign bus.rsp_err = mismatch;
    assign err         = mismatch;
`endif

    // Sequencer FSM; every HC194 pin and handshake output is registered here
    always_ff @(posedge Clk) begin
        if (MR) begin
            state         <= ST_IDLE;
            op_q          <= OP_HOLD;
            rem           <= '0;
            sr            <= '0;
            hc_mr_n       <= 1'b0;
            hc_s          <= 2'b00;
            hc_dsr        <= 1'b0;
            hc_dsl        <= 1'b0;
            hc_d          <= 4'h0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 4'h0;
        end else begin
            hc_mr_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        op_q          <= cmd_op;
                        if (cmd_op == OP_LOAD) begin
                            hc_s  <= OP_LOAD;
                            hc_d  <= bus.cmd_data[3:0];
                            rem   <= '0;
                            state <= ST_RUN;
                        end else if (cnt_eff == '0) begin
                            state <= ST_SETTLE;
                        end else begin
                            // Bit 0 goes out with the mode; the rest shift down one per cycle
                            hc_s   <= cmd_op;
                            hc_dsr <= (cmd_op == OP_SHR) && bus.cmd_data[0];
                            hc_dsl <= (cmd_op == OP_SHL) && bus.cmd_data[0];
                            sr     <= bus.cmd_data >> 1;
                            rem    <= cnt_eff - CNT_ONE;
                            state  <= ST_RUN;
                        end
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rem == '0) begin
                        hc_s   <= 2'b00;
                        hc_dsr <= 1'b0;
                        hc_dsl <= 1'b0;
                        hc_d   <= 4'h0;
                        state  <= ST_SETTLE;
                    end else begin
                        rem    <= rem - CNT_ONE;
                        hc_dsr <= (op_q == OP_SHR) && sr[0];
                        hc_dsl <= (op_q == OP_SHL) && sr[0];
                        sr     <= sr >> 1;
                    end
                end
                ST_SETTLE: begin
                    bus.rsp_data  <= hc_q;
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc194_seq.sv
// tb/tb_hc194_seq.sv - directed plus random bench for hc194_seq with an HC194 device and reference model
module tb_hc194_seq;

`ifdef HC194_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       MR;
    logic       err;
    logic       hc_mr_n;
    logic [1:0] hc_s;
    logic       hc_dsr;
    logic       hc_dsl;
    logic [3:0] hc_d;
    logic [3:0] hc_q;
    logic [3:0] dev_q;
    logic       force_zero = 1'b0;

    int tests = 0;
    int fails = 0;

    hc194_seq_if #(.DATA_W(16)) bus ();

    hc194_seq #(.DATA_W(16)) dut (
        .Clk     (Clk),
        .MR      (MR),
        .bus     (bus),
        .err     (err),
        .hc_mr_n (hc_mr_n),
        .hc_s    (hc_s),
        .hc_dsr  (hc_dsr),
        .hc_dsl  (hc_dsl),
        .hc_d    (hc_d),
        .hc_q    (hc_q)
    );

    always #5 Clk = ~Clk;

    // External HC194 part as seen on the board
    always @(posedge Clk) begin
        if (!hc_mr_n) dev_q <= 4'h0;
        else case (hc_s)
            2'b01:   dev_q <= {dev_q[2:0], hc_dsr};
            2'b10:   dev_q <= {hc_dsl, dev_q[3:1]};
            2'b11:   dev_q <= hc_d;
            default: dev_q <= dev_q;
        endcase
    end

    assign hc_q = force_zero ? 4'h0 : dev_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register contents after a command, from the HC194 mode rules
    function automatic logic [3:0] ref_next(input logic [3:0] q, input int op, input int cnt,
                                            input logic [15:0] data);
        int n;
        n = (cnt > 16) ? 16 : cnt;
        if (op == 3) return data[3:0];
        for (int i = 0; i < n; i++) begin
            if (op == 1) q = {q[2:0], data[i]};
            else if (op == 2) q = {data[i], q[3:1]};
        end
        return q;
    endfunction

    // Issue one command from a negedge, observe the pins, then complete the response
    task automatic run_cmd(input int op, input int cnt, input logic [15:0] data, input int hold,
                           input logic [3:0] exp_q, input logic exp_rerr);
        int n, el, exp_active, wait_c, lat, active, seq_n, stray;
        logic [15:0] seq;
        logic [31:0] exp_seq;
        logic [3:0]  dload, held;
        n          = (cnt > 16) ? 16 : cnt;
        el         = (op == 3) ? 3 : ((n == 0) ? 2 : n + 2);
        exp_active = (op == 3) ? 1 : ((op == 1 || op == 2) ? n : 0);
        exp_seq    = (op == 1 || op == 2) ? (32'(data) & ((32'h1 << n) - 32'h1)) : 32'h0;
        wait_c = 0; lat = 0; active = 0; seq_n = 0; stray = 0; seq = '0; dload = 4'h0;
        while (bus.cmd_ready !== 1'b1 && wait_c < 20) begin
            @(posedge Clk); @(negedge Clk); wait_c++;
        end
        check("cmd_ready_timeout", (wait_c < 20), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_cnt   = 5'(cnt);
        bus.cmd_data  = data;
        @(posedge Clk); @(negedge Clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.rsp_valid === 1'b1) begin lat = k; break; end
            if (hc_s != 2'b00) active++;
            case (hc_s)
                2'b11: dload = hc_d;
                2'b01: begin if (seq_n < 16) seq[seq_n] = hc_dsr; seq_n++; stray += int'(hc_dsl); end
                2'b10: begin if (seq_n < 16) seq[seq_n] = hc_dsl; seq_n++; stray += int'(hc_dsr); end
                default: stray += int'(hc_dsr | hc_dsl | (hc_d != 4'h0));
            endcase
            @(posedge Clk); @(negedge Clk);
        end
        check("latency", lat, el);
        check("active_cycles", active, exp_active);
        check("serial_seq", 32'(seq), exp_seq);
        check("stray_pins", stray, 0);
        if (op == 3) check("load_d", dload, data[3:0]);
        check("rsp_data", bus.rsp_data, exp_q);
        check("rsp_err", bus.rsp_err, exp_rerr);
        held = bus.rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); @(negedge Clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_data", bus.rsp_data, held);
        end
        bus.rsp_ready = 1'b1;
        check("no_cmd_ready_in_resp", bus.cmd_ready, 0);
        @(posedge Clk); @(negedge Clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("cmd_ready_after_resp", bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  refq;
        logic [15:0] rdata;
        int          op, cnt, seen;

        MR = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_cnt = '0; bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, err,
                              hc_s, hc_dsr, hc_dsl, hc_d}, 0);
        check("rst_hc_mr_n", hc_mr_n, 0);
        MR = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("first_cmd_ready", bus.cmd_ready, 1);
        check("hc_mr_n_release", hc_mr_n, 1);

        refq = 4'h0;
        run_cmd(3, 0, 16'h000A, 0, 4'hA, 1'b0); refq = 4'hA;
        run_cmd(3, 0, 16'h0000, 0, 4'h0, 1'b0); refq = 4'h0;
        run_cmd(1, 4, 16'h000D, 0, 4'hB, 1'b0); refq = 4'hB;
        run_cmd(2, 2, 16'h0001, 1, 4'h6, 1'b0); refq = 4'h6;
        run_cmd(1, 0, 16'hFFFF, 3, 4'h6, 1'b0);
        run_cmd(0, 3, 16'hFFFF, 0, 4'h6, 1'b0);
        rdata = 16'($urandom);
        run_cmd(1, 20, rdata, 0, ref_next(refq, 1, 20, rdata), 1'b0);
        refq = ref_next(refq, 1, 20, rdata);

        // Abort a long shift with MR in its 5th RUN cycle
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_cnt = 5'd10; bus.cmd_data = 16'($urandom);
        @(posedge Clk); @(negedge Clk);
        bus.cmd_valid = 1'b0;
        repeat (4) begin @(posedge Clk); @(negedge Clk); end
        MR = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("abort_hc_s", hc_s, 0);
        check("abort_hc_mr_n", hc_mr_n, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_cmd_ready", bus.cmd_ready, 0);
        MR = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("abort_cmd_ready_back", bus.cmd_ready, 1);
        seen = 0;
        repeat (12) begin
            seen += int'(bus.rsp_valid);
            @(posedge Clk); @(negedge Clk);
        end
        check("abort_no_rsp", seen, 0);
        refq = 4'h0;
        run_cmd(0, 2, 16'h0000, 0, 4'h0, 1'b0);

        // Corrupt the readback during a LOAD
        force_zero = 1'b1;
        run_cmd(3, 0, 16'h0005, 0, 4'h0, CHK);
        force_zero = 1'b0;
        refq = 4'h5;
        check("err_after_fault", err, CHK);

        for (int r = 0; r < 30; r++) begin
            op    = int'($urandom_range(0, 3));
            cnt   = int'($urandom_range(0, 18));
            rdata = 16'($urandom);
            run_cmd(op, cnt, rdata, int'($urandom_range(0, 2)), ref_next(refq, op, cnt, rdata), 1'b0);
            refq = ref_next(refq, op, cnt, rdata);
        end
        check("err_sticky", err, CHK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
